pattern_buffer_bank: RTL

//  Parametrised successor to the 8x27-byte pattern store. Holds NBUFS pattern buffers of BUFSIZE

---
 rtl/pattern_buffer_bank_pkg.sv | 21 ++
 rtl/pattern_buffer_bank_if.sv | 16 +
 rtl/pattern_buffer_bank_shift_ctrl.sv | 108 ++++++++++
 rtl/pattern_buffer_bank.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pattern_buffer_bank_pkg.sv
// Shared definitions for the pattern buffer bank: shift FSM state type,
// default geometry constants and a width helper.
package pattern_pkg;

  localparam int unsigned DEF_NBUFS   = 8;
  localparam int unsigned DEF_BUFSIZE = 27;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NSEQ    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_buffer_bank_if.sv
// Serial configuration port of the pattern buffer bank.
//   ssel  : frame select (host -> bank)
//   saddr : target buffer, latched by the bank at frame start
//   sin   : serial data, MSB of field 0 first
//   sout  : serial readback of the shadow register MSB (bank -> host)
interface pattern_buffer_bank_if #(
  parameter int unsigned AW = 3
) ();
  logic          ssel;
  logic [AW-1:0] saddr;
  logic          sin;
  logic          sout;

  modport master (output ssel, output saddr, output sin, input sout);
  modport slave  (input ssel, input saddr, input sin, output sout);
endinterface

// File: rtl/pattern_buffer_bank_shift_ctrl.sv
// Serial load controller: frame FSM, bit counter, shared shadow register and
// sticky frame-error flag.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_ssel/i_saddr/i_sin : serial frame inputs
//   i_load_data    : shadow-ordered image of active[i_saddr] (field 0 in the MSBs)
//   o_ch           : buffer latched at frame start
//   o_shadow       : shadow register contents
//   o_commit       : high for the single COMMIT cycle
//   o_frame_err    : sticky short/long frame flag
//   o_sout         : shadow MSB
module pattern_shift_ctrl
  import pattern_pkg::*;
#(
  parameter int unsigned FRAME = 216,
  parameter int unsigned AW    = 3,
  parameter int unsigned CW    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ssel,
  input  logic [AW-1:0]    i_saddr,
  input  logic             i_sin,
  input  logic [FRAME-1:0] i_load_data,
  output logic [AW-1:0]    o_ch,
  output logic [FRAME-1:0] o_shadow,
  output logic             o_commit,
  output logic             o_frame_err,
  output logic             o_sout
);

  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [FRAME-1:0] r_shadow, w_shadow_nxt;
  logic [AW-1:0]    r_ch, w_ch_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             r_err, w_err_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ch     <= '0;
      r_ovr    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_ch     <= w_ch_nxt;
      r_ovr    <= w_ovr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_ch_nxt     = r_ch;
    w_ovr_nxt    = r_ovr;
    w_err_nxt    = r_err;
    o_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_ssel) begin
          w_ch_nxt     = i_saddr;
          w_shadow_nxt = i_load_data;
          w_cnt_nxt    = '0;
          w_ovr_nxt    = 1'b0;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ssel) begin
          w_shadow_nxt = {r_shadow[FRAME-2:0], i_sin};
          // Counter saturates at FRAME; any shift beyond that is an overrun
          // remembered for this frame so the frame cannot commit.
          if (r_cnt == FRAME_CNT) begin
            w_ovr_nxt = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_cnt == FRAME_CNT && !r_ovr) begin
          w_state_nxt = COMMIT;
        end else begin
          w_err_nxt    = 1'b1;
          w_shadow_nxt = '0;
          w_state_nxt  = IDLE;
        end
      end
      COMMIT: begin
        o_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_ch        = r_ch;
  assign o_shadow    = r_shadow;
  assign o_frame_err = r_err;
  assign o_sout      = r_shadow[FRAME-1];

endmodule

// File: rtl/pattern_buffer_bank.sv
// Bank of NBUFS pattern buffers (BUFSIZE fields of WIDTH bits) loaded over a
// serial port through one shadow register that commits atomically, plus NSEQ
// writable sequence registers aliasing field indices 0..NSEQ-1 on field_byte.
//   sclk, rst_n      : clock, async active-low reset
//   ser              : serial config port (ssel, saddr, sin, sout)
//   bufp, fieldp     : core-side buffer / field select
//   field_byte       : selected field (sequence register for fieldp < NSEQ)
//   current_buffer   : active[bufp], field i at [i*WIDTH +: WIDTH]
//   pattern_sequence : sequence registers, same flattening
//   seq_we/idx/wdata : sequence register write port (idx >= NSEQ ignored)
//   commit_done      : one-cycle pulse while a buffer commits
//   frame_err        : sticky short/long frame flag
module pattern_buffer_bank
  import pattern_pkg::*;
#(
  parameter int unsigned NBUFS   = DEF_NBUFS,
  parameter int unsigned BUFSIZE = DEF_BUFSIZE,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NSEQ    = DEF_NSEQ,
  localparam int unsigned AW     = clog2_min1(NBUFS),
  localparam int unsigned FW     = clog2_min1(BUFSIZE),
  localparam int unsigned FRAME  = BUFSIZE * WIDTH,
  localparam int unsigned SIW    = clog2_min1(NSEQ)
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  pattern_buffer_bank_if.slave    ser,
  input  logic [AW-1:0]           bufp,
  input  logic [FW-1:0]           fieldp,
  output logic [WIDTH-1:0]        field_byte,
  output logic [FRAME-1:0]        current_buffer,
  output logic [NSEQ*WIDTH-1:0]   pattern_sequence,
  input  logic                    seq_we,
  input  logic [SIW-1:0]          seq_idx,
  input  logic [WIDTH-1:0]        seq_wdata,
  output logic                    commit_done,
  output logic                    frame_err
);

  localparam int unsigned CW = $clog2(FRAME + 1);

  logic [FRAME-1:0] r_active [NBUFS];
  logic [WIDTH-1:0] r_seq    [NSEQ];

  logic [FRAME-1:0] w_sel_load;
  logic [FRAME-1:0] w_load_img;
  logic [FRAME-1:0] w_shadow;
  logic [FRAME-1:0] w_commit_img;
  logic [FRAME-1:0] w_core_buf;
  logic [AW-1:0]    w_ch;
  logic             w_commit;
  logic             w_sout;
  logic             w_frame_err;

  always_comb begin
    w_sel_load = '0;
    if (32'(ser.saddr) < NBUFS) w_sel_load = r_active[ser.saddr];
  end

  // The shadow shifts MSB-first with field 0 entering first, so field 0 sits
  // in the shadow's top bits while the active layout keeps field 0 at bit 0;
  // fields are reversed (bits within a field untouched) in both directions.
  always_comb begin
    w_load_img   = '0;
    w_commit_img = '0;
    for (int unsigned i = 0; i < BUFSIZE; i++) begin
      w_load_img[(BUFSIZE-1-i)*WIDTH +: WIDTH] = w_sel_load[i*WIDTH +: WIDTH];
      w_commit_img[i*WIDTH +: WIDTH]           = w_shadow[(BUFSIZE-1-i)*WIDTH +: WIDTH];
    end
  end

  pattern_shift_ctrl #(
    .FRAME (FRAME),
    .AW    (AW),
    .CW    (CW)
  ) u_shift_ctrl (
    .i_clk       (sclk),
    .i_rst_n     (rst_n),
    .i_ssel      (ser.ssel),
    .i_saddr     (ser.saddr),
    .i_sin       (ser.sin),
    .i_load_data (w_load_img),
    .o_ch        (w_ch),
    .o_shadow    (w_shadow),
    .o_commit    (w_commit),
    .o_frame_err (w_frame_err),
    .o_sout      (w_sout)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NBUFS; b++) r_active[b] <= '0;
    end else if (w_commit && (32'(w_ch) < NBUFS)) begin
      r_active[w_ch] <= w_commit_img;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NSEQ; s++) r_seq[s] <= '0;
    end else if (seq_we && (32'(seq_idx) < NSEQ)) begin
      r_seq[seq_idx] <= seq_wdata;
    end
  end

  always_comb begin
    w_core_buf = '0;
    if (32'(bufp) < NBUFS) w_core_buf = r_active[bufp];
  end

  always_comb begin
    field_byte = '0;
    if (32'(fieldp) < NSEQ)
      field_byte = r_seq[fieldp[SIW-1:0]];
    else if (32'(fieldp) < BUFSIZE)
      field_byte = w_core_buf[32'(fieldp)*WIDTH +: WIDTH];
  end

  always_comb begin
    pattern_sequence = '0;
    for (int unsigned s = 0; s < NSEQ; s++)
      pattern_sequence[s*WIDTH +: WIDTH] = r_seq[s];
  end

  assign current_buffer = w_core_buf;
  assign commit_done    = w_commit;
  assign frame_err      = w_frame_err;
  assign ser.sout       = w_sout;

endmodule
